// File: rtl/mmu_pkg.sv
// Shared MMU definitions: command encoding, controller states, array geometry.
package mmu_pkg;

  localparam int unsigned MMU_DIM   = 4;
  localparam int unsigned MMU_DRAIN = 6;

  // MMU command opcodes (zero-extended onto the ACLEN+1 bit command port)
  typedef enum logic [2:0] {
    CMD_RESET            = 3'd0,
    CMD_TRIGGER          = 3'd1,
    CMD_SET_MUL_VAL      = 3'd2,
    CMD_SET_ADD_VAL      = 3'd3,
    CMD_SET_PE_VAL       = 3'd4,
    CMD_SET_CONV_MODE    = 3'd5,
    CMD_SET_FIX_MAC_MODE = 3'd6,
    CMD_IDLE             = 3'd7
  } mmu_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FEED,
    ST_DRAIN,
    ST_WAIT,
    ST_OUT
  } ctrl_state_e;

endpackage

// File: rtl/mmu_tile_ctrl_if.sv
// Job request and result stream between a host and mmu_tile_ctrl.
//   start_*  : job request (valid/ready), K, base address, accumulate flag
//   res_*    : 128-bit result beats (valid/ready), last flag
//   done     : one-cycle pulse after the final beat transfers
// master = host side, slave = controller side.
interface mmu_tile_ctrl_if
  import mmu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KW         = 16,
  parameter int unsigned AW         = 16
) ();

  logic                          start_valid;
  logic                          start_ready;
  logic [KW-1:0]                 start_k;
  logic [AW-1:0]                 start_base;
  logic                          start_accum;
  logic                          res_valid;
  logic                          res_ready;
  logic [MMU_DIM*DATA_WIDTH-1:0] res_data;
  logic                          res_last;
  logic                          done;

  modport master (
    output start_valid, start_k, start_base, start_accum, res_ready,
    input  start_ready, res_valid, res_data, res_last, done
  );

  modport slave (
    input  start_valid, start_k, start_base, start_accum, res_ready,
    output start_ready, res_valid, res_data, res_last, done
  );

endinterface

// File: rtl/mmu_res_drain.sv
// Result serializer: emits the four MMU column read-outs as valid/ready beats.
//   i_start        : load beat 0 and raise valid (controller entering OUT)
//   i_rdata        : MMU rdata_1..4; beat b = i_rdata[b]
//   i_ready        : downstream accept
//   o_valid/o_data/o_last : beat stream, held stable while stalled
//   o_done         : one-cycle pulse after beat 3 transfers
//   o_last_xfer_c  : combinational, beat 3 transfers this cycle
module mmu_res_drain
  import mmu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         i_start,
  input  logic [MMU_DIM-1:0][MMU_DIM*DATA_WIDTH-1:0]   i_rdata,
  input  logic                                         i_ready,
  output logic                                         o_valid,
  output logic [MMU_DIM*DATA_WIDTH-1:0]                o_data,
  output logic                                         o_last,
  output logic                                         o_done,
  output logic                                         o_last_xfer_c
);

  localparam int unsigned BW  = MMU_DIM * DATA_WIDTH;
  localparam int unsigned BCW = $clog2(MMU_DIM);

  logic [BCW-1:0] r_beat, w_beat;
  logic           r_valid, w_valid;
  logic [BW-1:0]  r_data, w_data;
  logic           r_last, w_last;
  logic           r_done, w_done;

  // Next beat: advance only on handshake so data/last hold during stalls
  always_comb begin
    w_beat  = r_beat;
    w_valid = r_valid;
    w_data  = r_data;
    w_last  = r_last;
    w_done  = 1'b0;
    if (i_start) begin
      w_beat  = '0;
      w_valid = 1'b1;
      w_data  = i_rdata[0];
      w_last  = 1'b0;
    end else if (r_valid && i_ready) begin
      if (r_last) begin
        w_beat  = '0;
        w_valid = 1'b0;
        w_data  = '0;
        w_last  = 1'b0;
        w_done  = 1'b1;
      end else begin
        w_beat = r_beat + BCW'(1);
        w_data = i_rdata[w_beat];
        w_last = (w_beat == BCW'(MMU_DIM - 1));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_beat  <= w_beat;
      r_valid <= w_valid;
      r_data  <= w_data;
      r_last  <= w_last;
      r_done  <= w_done;
    end
  end

  assign o_valid       = r_valid;
  assign o_data        = r_data;
  assign o_last        = r_last;
  assign o_done        = r_done;
  assign o_last_xfer_c = r_valid && i_ready && r_last;

endmodule

// File: rtl/mmu_tile_ctrl.sv
// Tile sequencer for the 4x4 systolic MMU: clear, stream K operand vectors as
// TRIGGERs, flush the pipeline with zero TRIGGERs, wait for idle, read out.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   job_if (slave)         : job request and result beat stream
//   buf_rd_en/buf_rd_addr  : operand buffer read (1-cycle latency)
//   buf_data_i/buf_weight_i: operand lanes, lane r = [r*DW +: DW]
//   mmu_cmd_valid/mmu_cmd  : MMU command, IDLE whenever not valid
//   param_1_out/param_2_out: tied to 0
//   data_n_out/weight_n_out: MMU operand lanes
//   mmu_busy, rdata_n_in   : MMU status and column read-outs
module mmu_tile_ctrl
  import mmu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACLEN      = 4,
  parameter int unsigned KW         = 16,
  parameter int unsigned AW         = 16,
  parameter int unsigned DRAIN      = MMU_DRAIN
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  mmu_tile_ctrl_if.slave                             job_if,
  output logic                                       buf_rd_en,
  output logic [AW-1:0]                              buf_rd_addr,
  input  logic [MMU_DIM*DATA_WIDTH-1:0]              buf_data_i,
  input  logic [MMU_DIM*DATA_WIDTH-1:0]              buf_weight_i,
  output logic                                       mmu_cmd_valid,
  output logic [ACLEN:0]                             mmu_cmd,
  output logic [DATA_WIDTH-1:0]                      param_1_out,
  output logic [DATA_WIDTH-1:0]                      param_2_out,
  output logic [MMU_DIM-1:0][DATA_WIDTH-1:0]         data_n_out,
  output logic [MMU_DIM-1:0][DATA_WIDTH-1:0]         weight_n_out,
  input  logic                                       mmu_busy,
  input  logic [MMU_DIM-1:0][MMU_DIM*DATA_WIDTH-1:0] rdata_n_in
);

  localparam int unsigned CW  = ACLEN + 1;
  localparam int unsigned DCW = $clog2(DRAIN + 1);

  ctrl_state_e    r_state, w_state_nxt;
  logic [KW-1:0]  r_k, w_k_nxt;
  logic [AW-1:0]  r_base, w_base_nxt;
  logic [KW-1:0]  r_idx, w_idx_nxt;
  logic [DCW-1:0] r_drn, w_drn_nxt;
  logic           r_start_ready, w_start_ready_nxt;
  logic           r_rd_en, w_rd_en_nxt;
  logic [AW-1:0]  r_rd_addr, w_rd_addr_nxt;
  logic           r_trig_data, w_trig_data_nxt;
  logic           w_trig_nxt;
  logic           r_cmd_valid, w_cmd_valid_nxt;
  mmu_cmd_e       r_cmd, w_cmd_nxt;
  logic           w_out_start;
  logic           w_last_xfer;

  // Next state, counters and registered outputs.
  // DRAIN lasts DRAIN+1 cycles: its first cycle carries the TRIGGER for the
  // last buffer read, the remaining DRAIN cycles carry zero-vector TRIGGERs.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_base_nxt  = r_base;
    w_idx_nxt   = r_idx;
    w_drn_nxt   = r_drn;

    unique case (r_state)
      ST_IDLE: begin
        if (job_if.start_valid) begin
          w_k_nxt    = job_if.start_k;
          w_base_nxt = job_if.start_base;
          w_idx_nxt  = '0;
          if (!job_if.start_accum)        w_state_nxt = ST_CLR;
          else if (job_if.start_k != '0)  w_state_nxt = ST_FEED;
          else                            w_state_nxt = ST_WAIT;
        end
      end
      ST_CLR:  w_state_nxt = (r_k != '0) ? ST_FEED : ST_WAIT;
      ST_FEED: begin
        if (r_idx == r_k - KW'(1)) begin
          w_state_nxt = ST_DRAIN;
          w_drn_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (r_drn == DCW'(DRAIN)) w_state_nxt = ST_WAIT;
        else                      w_drn_nxt   = r_drn + DCW'(1);
      end
      ST_WAIT: if (!mmu_busy)   w_state_nxt = ST_OUT;
      ST_OUT:  if (w_last_xfer) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    w_start_ready_nxt = (w_state_nxt == ST_IDLE);
    w_rd_en_nxt       = (w_state_nxt == ST_FEED);
    w_rd_addr_nxt     = w_rd_en_nxt ? (w_base_nxt + AW'(w_idx_nxt)) : '0;
    // TRIGGER lands one cycle after each read, when the buffer data arrives
    w_trig_data_nxt   = (r_state == ST_FEED);
    w_trig_nxt        = w_trig_data_nxt || ((r_state == ST_DRAIN) && (r_drn != DCW'(DRAIN)));
    w_cmd_valid_nxt   = w_trig_nxt || (w_state_nxt == ST_CLR);
    if (w_state_nxt == ST_CLR) w_cmd_nxt = CMD_RESET;
    else if (w_trig_nxt)       w_cmd_nxt = CMD_TRIGGER;
    else                       w_cmd_nxt = CMD_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_k           <= '0;
      r_base        <= '0;
      r_idx         <= '0;
      r_drn         <= '0;
      r_start_ready <= 1'b1;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_trig_data   <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd         <= CMD_IDLE;
    end else begin
      r_state       <= w_state_nxt;
      r_k           <= w_k_nxt;
      r_base        <= w_base_nxt;
      r_idx         <= w_idx_nxt;
      r_drn         <= w_drn_nxt;
      r_start_ready <= w_start_ready_nxt;
      r_rd_en       <= w_rd_en_nxt;
      r_rd_addr     <= w_rd_addr_nxt;
      r_trig_data   <= w_trig_data_nxt;
      r_cmd_valid   <= w_cmd_valid_nxt;
      r_cmd         <= w_cmd_nxt;
    end
  end

  assign w_out_start = (r_state == ST_WAIT) && !mmu_busy;

  mmu_res_drain #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_res_drain (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_start       (w_out_start),
    .i_rdata       (rdata_n_in),
    .i_ready       (job_if.res_ready),
    .o_valid       (job_if.res_valid),
    .o_data        (job_if.res_data),
    .o_last        (job_if.res_last),
    .o_done        (job_if.done),
    .o_last_xfer_c (w_last_xfer)
  );

  assign job_if.start_ready = r_start_ready;
  assign buf_rd_en          = r_rd_en;
  assign buf_rd_addr        = r_rd_addr;
  assign mmu_cmd_valid      = r_cmd_valid;
  assign mmu_cmd            = CW'(r_cmd);
  assign param_1_out        = '0;
  assign param_2_out        = '0;
  // Operands pass straight from the buffer during data TRIGGERs, zero otherwise
  assign data_n_out         = r_trig_data ? buf_data_i   : '0;
  assign weight_n_out       = r_trig_data ? buf_weight_i : '0;

endmodule

// File: tb/tb_mmu_tile_ctrl.sv
// Directed bench for mmu_tile_ctrl with a fixed-MAC MMU model and a 1-cycle buffer.
module tb_mmu_tile_ctrl;

  logic clk;
  logic rst_i;
  logic buf_rd_en;
  logic [15:0] buf_rd_addr;
  logic [127:0] buf_data, buf_weight;
  logic mmu_cmd_valid;
  logic [4:0] mmu_cmd;
  logic [31:0] param_1, param_2;
  logic [3:0][31:0] data_n, weight_n;
  logic mmu_busy;
  logic [3:0][127:0] rdata;

  mmu_tile_ctrl_if u_if ();

  mmu_tile_ctrl u_dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .job_if        (u_if),
    .buf_rd_en     (buf_rd_en),
    .buf_rd_addr   (buf_rd_addr),
    .buf_data_i    (buf_data),
    .buf_weight_i  (buf_weight),
    .mmu_cmd_valid (mmu_cmd_valid),
    .mmu_cmd       (mmu_cmd),
    .param_1_out   (param_1),
    .param_2_out   (param_2),
    .data_n_out    (data_n),
    .weight_n_out  (weight_n),
    .mmu_busy      (mmu_busy),
    .rdata_n_in    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffer, 1-cycle read latency, low 8 address bits decoded
  logic [127:0] mem_d [256];
  logic [127:0] mem_w [256];
  always @(posedge clk) begin
    if (buf_rd_en) begin
      buf_data   <= mem_d[buf_rd_addr[7:0]];
      buf_weight <= mem_w[buf_rd_addr[7:0]];
    end
  end

  // Fixed-MAC MMU model: acc[r][c] += data[r]*weight[c]; column c read-out, row 0 in MSBs
  logic [31:0] acc [4][4];
  always @(posedge clk) begin
    if (mmu_cmd_valid && mmu_cmd == 5'd0) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) acc[r][c] <= 32'd0;
    end else if (mmu_cmd_valid && mmu_cmd == 5'd1) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) acc[r][c] <= acc[r][c] + 32'(data_n[r] * weight_n[c]);
    end
  end
  always_comb begin
    for (int c = 0; c < 4; c++) rdata[c] = {acc[0][c], acc[1][c], acc[2][c], acc[3][c]};
  end

  // Command / read monitor
  int cyc = 0, n_rd = 0, n_trig = 0, n_rst = 0;
  int rd_q[$];
  int trig_q[$];
  logic [15:0] addr_q[$];
  always @(negedge clk) begin
    cyc++;
    if (buf_rd_en) begin n_rd++; rd_q.push_back(cyc); addr_q.push_back(buf_rd_addr); end
    if (mmu_cmd_valid && mmu_cmd == 5'd1) begin n_trig++; trig_q.push_back(cyc); end
    if (mmu_cmd_valid && mmu_cmd == 5'd0) n_rst++;
  end

  int n_vec = 0, n_err = 0;
  int s_rd, s_trig, s_rst;
  logic [127:0] exp_b [4];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ln(input int a0, input int a1, input int a2, input int a3);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [127:0] col(input int r0, input int r1, input int r2, input int r3);
    return {32'(r0), 32'(r1), 32'(r2), 32'(r3)};
  endfunction

  task automatic start_job(input logic [15:0] k, input logic [15:0] base, input logic accum);
    int t = 0;
    @(negedge clk);
    while (!u_if.start_ready && t < 100) begin @(negedge clk); t++; end
    chk("start_ready_idle", u_if.start_ready, 1);
    s_rd = n_rd; s_trig = n_trig; s_rst = n_rst;
    u_if.start_valid = 1'b1;
    u_if.start_k     = k;
    u_if.start_base  = base;
    u_if.start_accum = accum;
    @(negedge clk);
    u_if.start_valid = 1'b0;
    chk("start_ready_busy", u_if.start_ready, 0);
  endtask

  task automatic drain_beats(input bit stall, input string tag);
    int b = 0, t = 0, ph = 0;
    while (b < 4 && t < 300) begin
      u_if.res_ready = stall ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      if (u_if.res_valid) begin
        ph++;
        chk({tag, "_beat"}, u_if.res_data, exp_b[b]);
        chk({tag, "_last"}, u_if.res_last, (b == 3));
        chk({tag, "_srdy_out"}, u_if.start_ready, 0);
        if (u_if.res_ready) b++;
      end
      @(negedge clk);
      t++;
    end
    u_if.res_ready = 1'b0;
    if (b < 4) begin
      chk({tag, "_beat_timeout"}, b, 4);
    end else begin
      chk({tag, "_done"}, u_if.done, 1);
      chk({tag, "_valid_off"}, u_if.res_valid, 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, u_if.done, 0);
      chk({tag, "_idle_ready"}, u_if.start_ready, 1);
    end
  endtask

  task automatic chk_cmds(input string tag, input int rd, input int trig, input int rst);
    chk({tag, "_rd_cnt"}, n_rd - s_rd, rd);
    chk({tag, "_trig_cnt"}, n_trig - s_trig, trig);
    chk({tag, "_rst_cnt"}, n_rst - s_rst, rst);
    if (trig > 0 && n_trig - s_trig == trig)
      chk({tag, "_trig_gap"}, trig_q[n_trig-1] - trig_q[s_trig] + 1, trig);
    if (rd > 0 && n_rd - s_rd == rd && n_trig - s_trig == trig && trig > 0)
      chk({tag, "_trig_lat"}, trig_q[s_trig] - rd_q[s_rd], 1);
  endtask

  task automatic set_s1_exp();
    exp_b[0] = col(5, 10, 15, 20);
    exp_b[1] = col(6, 12, 18, 24);
    exp_b[2] = col(7, 14, 21, 28);
    exp_b[3] = col(8, 16, 24, 32);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    mmu_busy = 1'b0;
    u_if.start_valid = 1'b0;
    u_if.start_k = '0;
    u_if.start_base = '0;
    u_if.start_accum = 1'b0;
    u_if.res_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin mem_d[i] = '0; mem_w[i] = '0; end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_start_ready", u_if.start_ready, 1);
    chk("rst_cmd", mmu_cmd, 7);
    chk("rst_cmd_valid", mmu_cmd_valid, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_res_valid", u_if.res_valid, 0);
    chk("rst_done", u_if.done, 0);
    chk("rst_params", {param_1, param_2}, 0);
    rst_i = 1'b0;

    // 1: K=1, {1,2,3,4} x {5,6,7,8}
    mem_d[8'h20] = ln(1, 2, 3, 4);
    mem_w[8'h20] = ln(5, 6, 7, 8);
    set_s1_exp();
    start_job(16'd1, 16'h0020, 1'b0);
    drain_beats(1'b0, "s1");
    chk_cmds("s1", 1, 7, 1);

    // 2: K=4, identity x weight rows 1..16, base wraps through 0xFFFF
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a;
      a = 16'hFFFE + 16'(i);
      mem_d[a[7:0]] = ln(int'(i == 0), int'(i == 1), int'(i == 2), int'(i == 3));
      mem_w[a[7:0]] = ln(4*i+1, 4*i+2, 4*i+3, 4*i+4);
    end
    exp_b[0] = col(1, 5, 9, 13);
    exp_b[1] = col(2, 6, 10, 14);
    exp_b[2] = col(3, 7, 11, 15);
    exp_b[3] = col(4, 8, 12, 16);
    start_job(16'd4, 16'hFFFE, 1'b0);
    drain_beats(1'b0, "s2");
    chk_cmds("s2", 4, 10, 1);
    if (n_rd - s_rd == 4)
      for (int i = 0; i < 4; i++) chk("s2_rd_addr", addr_q[s_rd+i], 16'(16'hFFFE + i));

    // 3: K=0, clear only
    for (int b = 0; b < 4; b++) exp_b[b] = '0;
    start_job(16'd0, 16'h0040, 1'b0);
    drain_beats(1'b0, "s3");
    chk_cmds("s3", 0, 0, 1);

    // 4: {1..4}x{1..4}, then the same job accumulated
    mem_d[8'h30] = ln(1, 2, 3, 4);
    mem_w[8'h30] = ln(1, 2, 3, 4);
    exp_b[0] = col(1, 2, 3, 4);
    exp_b[1] = col(2, 4, 6, 8);
    exp_b[2] = col(3, 6, 9, 12);
    exp_b[3] = col(4, 8, 12, 16);
    start_job(16'd1, 16'h0030, 1'b0);
    drain_beats(1'b0, "s4a");
    chk_cmds("s4a", 1, 7, 1);
    exp_b[0] = col(2, 4, 6, 8);
    exp_b[1] = col(4, 8, 12, 16);
    exp_b[2] = col(6, 12, 18, 24);
    exp_b[3] = col(8, 16, 24, 32);
    start_job(16'd1, 16'h0030, 1'b1);
    drain_beats(1'b0, "s4b");
    chk_cmds("s4b", 1, 7, 0);

    // 5: busy held 10 cycles in WAIT, then a stalling consumer
    mmu_busy = 1'b1;
    set_s1_exp();
    start_job(16'd1, 16'h0020, 1'b0);
    begin
      int t = 0;
      while (!((n_trig - s_trig == 7) && !mmu_cmd_valid) && t < 100) begin @(negedge clk); t++; end
      chk("s5_reach_wait", n_trig - s_trig, 7);
    end
    for (int i = 0; i < 10; i++) begin
      chk("s5_wait_valid", u_if.res_valid, 0);
      chk("s5_wait_srdy", u_if.start_ready, 0);
      @(negedge clk);
    end
    mmu_busy = 1'b0;
    drain_beats(1'b1, "s5");

    // 6: reset on the 3rd FEED cycle, then a fresh scenario-1 job
    start_job(16'd8, 16'h0020, 1'b0);
    begin
      int t = 0;
      while (!buf_rd_en && t < 20) begin @(negedge clk); t++; end
      chk("s6_feed_seen", buf_rd_en, 1);
    end
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("s6_rst_srdy", u_if.start_ready, 1);
    chk("s6_rst_rd", {buf_rd_en, buf_rd_addr}, 0);
    chk("s6_rst_cmd", {mmu_cmd_valid, mmu_cmd}, 7);
    chk("s6_rst_ops", {data_n, weight_n}, 0);
    chk("s6_rst_res", {u_if.res_valid, u_if.res_last, u_if.done}, 0);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s6_no_done", {u_if.done, u_if.res_valid, mmu_cmd_valid}, 0);
    end
    set_s1_exp();
    start_job(16'd1, 16'h0020, 1'b0);
    drain_beats(1'b0, "s6");
    chk_cmds("s6", 1, 7, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
